product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Sequential stage directly downstream of binary_multiplier.
- Consumes the 4-bit product on x0..x3 (x0 = LSB) through a valid/ready handshake and sums a fixed number of products (default 4) into a wider accumulator.
- Presents each finished sum with its own valid/ready handshake.
- Gives the combinational multiplier a registered, flow-controlled consumer for dot-product-style use.

Parameters:
- ACC_W, 8: accumulator and sum width in bits; minimum 4.
- TERMS, 4: number of products per result; minimum 1, maximum 2^CNT_W-1.
- CNT_W, 4: width of the term counter and the count output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  product on x0..x3 is valid.
- in_ready  output  1  block can accept a product this cycle.
- x0  input  1  product bit 0 (LSB).
- x1  input  1  product bit 1.
- x2  input  1  product bit 2.
- x3  input  1  product bit 3 (MSB).
- flush  input  1  close the current partial sum early.
- out_valid  output  1  sum/count/ovf are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  ACC_W  accumulated result.
- count  output  CNT_W  number of products included in sum.
- ovf  output  1  sum saturated during this result.

Behaviour:
- Reset: when rst is 1 at a clock edge, the next state is as follows.
  - State ACCUM.
  - acc=0, cnt=0, sum=0, count=0, ovf=0, out_valid=0.
  - in_ready=1.
  - Reset aborts any partial or held result; nothing is emitted.
- Product value: p = {x3,x2,x1,x0}, zero-extended to ACC_W.
- Accept condition: in_valid and in_ready.
- State ACCUM:
  - in_ready=1 and out_valid=0.
  - On accept: acc_next = acc+p, saturating at 2^ACC_W-1. If it saturates, set the sticky ovf_int. Then cnt_next = cnt+1.
  - If the accept makes cnt_next == TERMS, go to HOLD.
  - Else if flush=1 and cnt_next >= 1, go to HOLD. This applies whether or not an accept occurred; an accepted term in the same cycle is included.
  - flush=1 with cnt==0 and no accept is ignored; stay in ACCUM.
- Transition to HOLD: sum, count and ovf are registered from acc_next, cnt_next and ovf_int in the same edge, and out_valid=1.
  - Latency: result is visible in the cycle after the final accepted term.
- State HOLD:
  - in_ready=0, so products are back-pressured. in_valid may stay high; the held product is not consumed.
  - sum, count and ovf are stable while out_valid=1 and out_ready=0.
  - flush is ignored in HOLD.
- Leaving HOLD: when out_valid and out_ready:
  - Next state ACCUM, out_valid=0.
  - acc=0, cnt=0, ovf_int=0.
  - sum, count and ovf keep their last values but are don't-care while out_valid=0.
  - No accept is possible in the handoff cycle, because in_ready is 0 during HOLD.
- Throughput: one product per cycle in ACCUM. Each result costs at least one extra cycle in HOLD.
- in_ready is a pure function of state; it has no combinational path from out_ready.
- Values on x0..x3 are ignored when in_valid=0.

Test Plan:
- Reset, then 4 consecutive accepts of p=9 (x3=1, x0=1; a=3, b=3) with out_ready=0.
  - Required: in_ready drops the cycle after the 4th accept.
  - out_valid=1, sum=36, count=4, ovf=0, held stable for 3 cycles.
  - Raise out_ready: one-cycle transfer, then out_valid=0 and in_ready=1.
- Products 1, 2, 4, 6 with in_valid gapped (idle cycles between them), out_ready=1.
  - Required: sum=13, count=4, one cycle after the last accept.
  - Accumulator is zero afterwards: next 4 products of p=1 give sum=4.
- Products 3 and 2, with flush asserted in the same cycle as the product 2.
  - Required: sum=5, count=2.
  - flush alone with cnt=0 produces no out_valid.
- ACC_W=5: accept 9, 9, 9, 9.
  - Required: sum=31 (saturated), ovf=1, count=4.
  - Next result 1, 1, 1, 1 gives sum=4 and ovf=0.
- Backpressure: hold in_valid=1 with p=9 continuously and out_ready=0 for 5 cycles.
  - Required: exactly 4 accepts, then in_ready=0.
  - No accept occurs until the result is taken; the 5th product lands in the next result.
- Reset mid-operation: after 2 accepts (p=4, 4), assert rst for 1 cycle.
  - Required: out_valid=0, in_ready=1.
  - Next 4 products of p=1 give sum=4, count=4, with no residue of 8.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator
//   Registered, flow-controlled consumer for a 4-bit multiplier product.
//   Sums TERMS products (or fewer, when flush closes a result early) into a
//   saturating ACC_W-bit accumulator, then holds the result until downstream
//   takes it.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  product handshake; in_ready depends only on state
//   x0..x3             product bits, x0 = LSB
//   flush              close the current partial sum early (ACCUM only)
//   out_valid/out_ready result handshake
//   sum, count, ovf    result, number of products in it, saturation flag
module product_accumulator #(
  parameter int ACC_W = 8,
  parameter int TERMS = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             x0,
  input  logic             x1,
  input  logic             x2,
  input  logic             x3,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] TERMS_C = CNT_W'(TERMS);

  state_t           r_state, w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_int;
  logic [ACC_W-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic [ACC_W-1:0] w_p;
  logic [ACC_W:0]   w_raw;
  logic             w_accept;
  logic             w_sat;
  logic [ACC_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_ovf_next;
  logic             w_to_hold;
  logic             w_release;

  assign w_p      = ACC_W'({x3, x2, x1, x0});
  assign in_ready = (r_state == ACCUM);
  assign out_valid = (r_state == HOLD);
  assign sum      = r_sum;
  assign count    = r_count;
  assign ovf      = r_ovf;

  assign w_accept  = in_valid && in_ready;
  assign w_release = out_valid && out_ready;

  // One extra bit catches the carry that signals saturation.
  assign w_raw = {1'b0, r_acc} + {1'b0, w_p};
  assign w_sat = w_accept && w_raw[ACC_W];

  always_comb begin
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_ovf_next   = r_ovf_int;
    w_to_hold    = 1'b0;
    w_state_next = r_state;
    if (w_accept) begin
      w_acc_next = w_sat ? {ACC_W{1'b1}} : w_raw[ACC_W-1:0];
      w_cnt_next = r_cnt + 1'b1;
      w_ovf_next = r_ovf_int | w_sat;
    end
    case (r_state)
      ACCUM: begin
        // A flush in the same cycle as an accept includes that term.
        if ((w_accept && w_cnt_next == TERMS_C) ||
            (flush && w_cnt_next != '0)) begin
          w_to_hold    = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (w_release) w_state_next = ACCUM;
      end
      default: w_state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ACCUM;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf_int <= 1'b0;
      r_sum     <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_to_hold) begin
        r_sum   <= w_acc_next;
        r_count <= w_cnt_next;
        r_ovf   <= w_ovf_next;
      end
      // Accumulator clears on handoff so the next result starts from zero.
      if (w_release) begin
        r_acc     <= '0;
        r_cnt     <= '0;
        r_ovf_int <= 1'b0;
      end else begin
        r_acc     <= w_acc_next;
        r_cnt     <= w_cnt_next;
        r_ovf_int <= w_ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  // default-width instance (ACC_W=8)
  logic       in_valid, in_ready, flush, out_valid, out_ready, ovf;
  logic [3:0] p;
  logic [7:0] sum;
  logic [3:0] count;
  // narrow instance (ACC_W=5) for saturation
  logic       in_valid5, in_ready5, flush5, out_valid5, out_ready5, ovf5;
  logic [3:0] p5;
  logic [4:0] sum5;
  logic [3:0] count5;

  int checks = 0;
  int errors = 0;

  product_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x0(p[0]), .x1(p[1]), .x2(p[2]), .x3(p[3]), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .count(count), .ovf(ovf)
  );

  product_accumulator #(.ACC_W(5), .TERMS(4), .CNT_W(4)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
    .x0(p5[0]), .x1(p5[1]), .x2(p5[2]), .x3(p5[3]), .flush(flush5),
    .out_valid(out_valid5), .out_ready(out_ready5),
    .sum(sum5), .count(count5), .ovf(ovf5)
  );

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'd0 ||
        count !== 4'd0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: ov=%b ir=%b sum=%0d cnt=%0d ovf=%b, need ov=0 ir=1 sum=0 cnt=0 ovf=0",
               out_valid, in_ready, sum, count, ovf);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    p         = 4'd9;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_ready_%0d: in_ready=%b need 1", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== 8'd36 ||
          count !== 4'd4 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL basic_hold_%0d: ir=%b ov=%b sum=%0d cnt=%0d ovf=%b, need ir=0 ov=1 sum=36 cnt=4 ovf=0",
                 i, in_ready, out_valid, sum, count, ovf);
      end
      if (i < 3) tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: ov=%b ir=%b need ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_gapped();
    logic [3:0] vals [4] = '{4'd1, 4'd2, 4'd4, 4'd6};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      p        = vals[i];
      tick();
      in_valid = 1'b0;
      p        = 4'd15;  // garbage while idle must be ignored
      checks++;
      if (i < 3) begin
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL gapped_early_%0d: out_valid=%b need 0", i, out_valid);
        end
      end else if (out_valid !== 1'b1 || sum !== 8'd13 || count !== 4'd4) begin
        errors++;
        $display("FAIL gapped_result: ov=%b sum=%0d cnt=%0d need ov=1 sum=13 cnt=4",
                 out_valid, sum, count);
      end
      tick();
    end
    // accumulator must be clear: four ones give 4
    in_valid = 1'b1;
    p        = 4'd1;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'd4 || count !== 4'd4) begin
      errors++;
      $display("FAIL gapped_cleared: ov=%b sum=%0d cnt=%0d need ov=1 sum=4 cnt=4",
               out_valid, sum, count);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    p         = 4'd3;
    tick();
    p     = 4'd2;
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'd5 || count !== 4'd2) begin
      errors++;
      $display("FAIL flush_result: ov=%b sum=%0d cnt=%0d need ov=1 sum=5 cnt=2",
               out_valid, sum, count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    flush     = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_empty_%0d: out_valid=%b need 0", i, out_valid);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_saturate();
    out_ready5 = 1'b0;
    in_valid5  = 1'b1;
    p5         = 4'd9;
    for (int i = 0; i < 4; i++) tick();
    in_valid5 = 1'b0;
    checks++;
    if (out_valid5 !== 1'b1 || sum5 !== 5'd31 || ovf5 !== 1'b1 || count5 !== 4'd4) begin
      errors++;
      $display("FAIL sat_result: ov=%b sum=%0d ovf=%b cnt=%0d need ov=1 sum=31 ovf=1 cnt=4",
               out_valid5, sum5, ovf5, count5);
    end
    out_ready5 = 1'b1;
    tick();
    out_ready5 = 1'b0;
    in_valid5  = 1'b1;
    p5         = 4'd1;
    for (int i = 0; i < 4; i++) tick();
    in_valid5 = 1'b0;
    checks++;
    if (out_valid5 !== 1'b1 || sum5 !== 5'd4 || ovf5 !== 1'b0 || count5 !== 4'd4) begin
      errors++;
      $display("FAIL sat_next: ov=%b sum=%0d ovf=%b cnt=%0d need ov=1 sum=4 ovf=0 cnt=4",
               out_valid5, sum5, ovf5, count5);
    end
    out_ready5 = 1'b1;
    tick();
    out_ready5 = 1'b0;
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    p         = 4'd9;
    for (int i = 0; i < 5; i++) begin
      if (in_ready) n_acc++;
      tick();
    end
    checks++;
    if (n_acc != 4 || in_ready !== 1'b0 || sum !== 8'd36 || count !== 4'd4) begin
      errors++;
      $display("FAIL bp_stall: accepts=%0d ir=%b sum=%0d cnt=%0d need accepts=4 ir=0 sum=36 cnt=4",
               n_acc, in_ready, sum, count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    // the still-presented product starts the next result
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'd36 || count !== 4'd4) begin
      errors++;
      $display("FAIL bp_next: ov=%b sum=%0d cnt=%0d need ov=1 sum=36 cnt=4",
               out_valid, sum, count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    p        = 4'd4;
    tick();
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_state: ov=%b ir=%b need ov=0 ir=1", out_valid, in_ready);
    end
    in_valid = 1'b1;
    p        = 4'd1;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'd4 || count !== 4'd4) begin
      errors++;
      $display("FAIL rstmid_next: ov=%b sum=%0d cnt=%0d need ov=1 sum=4 cnt=4",
               out_valid, sum, count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; p = 4'd0;
    in_valid5 = 1'b0; flush5 = 1'b0; out_ready5 = 1'b0; p5 = 4'd0;
    #2;
    test_reset();
    test_basic();
    test_gapped();
    test_flush();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
